// File: rtl/multicycle_control_fsm_if.sv
// Bundles the instruction fields, memory handshake and datapath strobes
// exchanged between the multi-cycle MIPS controller and its datapath.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       ir_load;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;
    logic       mem_timeout;

    // Controller side: consumes decoded fields and memory status, drives strobes.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output ir_load, pc_write, pc_write_cond, iord, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal, mem_timeout
    );

    // Datapath side: supplies decoded fields and memory status, obeys strobes.
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  ir_load, pc_write, pc_write_cond, iord, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal, mem_timeout
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main controller with memory-wait watchdog.
// Optional macro ILLEGAL_TRAP_EN: unsupported opcodes halt with a sticky illegal flag.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        ADDI_EX   = 4'd9,
        ADDI_WB   = 4'd10,
        JUMP      = 4'd11,
        HALT      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX);

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  illegal_q, illegal_d;
    logic                  mem_timeout_q, mem_timeout_d;

    logic                  in_mem_state;
    logic                  timeout_hit;

    // Field decode of funct and the zero flag live in ALU control and the PC
    // write logic; the controller only passes them by.
    logic unused_inputs;
    assign unused_inputs = ^{bus.funct, bus.zero};

    // Memory handshake: a request (mem_read/mem_write) is held steady while the
    // controller sits in a memory state; the access completes on the first
    // cycle mem_ready is sampled high, and the state advances on that edge.
    assign in_mem_state = (state_q == FETCH) || (state_q == MEM_READ) ||
                          (state_q == MEM_WRITE);
    assign timeout_hit  = in_mem_state && !bus.mem_ready && (wait_cnt_q == WAIT_LIMIT);

    always_comb begin
        wait_cnt_d = '0;
        if (in_mem_state && !bus.mem_ready && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_timeout_d = mem_timeout_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`else
        illegal_d     = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        state_d   = HALT;
`else
                        state_d   = FETCH;
`endif
                    end
                endcase
            end
            MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ: begin
                if (bus.mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECUTE:   state_d = ALU_WB;
            ALU_WB:    state_d = FETCH;
            BRANCH:    state_d = FETCH;
            ADDI_EX:   state_d = ADDI_WB;
            ADDI_WB:   state_d = FETCH;
            JUMP:      state_d = FETCH;
            HALT:      state_d = HALT;
            default:   state_d = FETCH;
        endcase

        // A stalled access overrides any normal transition.
        if (timeout_hit) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            wait_cnt_q    <= '0;
            illegal_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            illegal_q     <= illegal_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    logic       ir_load_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       mem_to_reg_s;
    logic       reg_dst_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;

    // Moore decode of the registered state; only FETCH looks at mem_ready so
    // the IR and PC capture on the exact cycle the fetch completes.
    always_comb begin
        ir_load_s       = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord_s          = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        mem_to_reg_s    = 1'b0;
        reg_dst_s       = 1'b0;
        reg_write_s     = 1'b0;
        alu_src_a_s     = 1'b0;
        alu_src_b_s     = 2'b00;
        alu_op_s        = 2'b00;
        pc_source_s     = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_load_s   = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            DECODE: begin
                alu_src_b_s = 2'b11;
            end
            MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            MEM_WRITE: begin
                mem_write_s = 1'b1;
                iord_s      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 2'b10;
            end
            ALU_WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_s     = 1'b1;
                alu_op_s        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_s     = 2'b01;
            end
            ADDI_EX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            ADDI_WB: begin
                reg_write_s = 1'b1;
            end
            JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_s = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign bus.ir_load       = ir_load_s;
    assign bus.pc_write      = pc_write_s;
    assign bus.pc_write_cond = pc_write_cond_s;
    assign bus.iord          = iord_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_write     = mem_write_s;
    assign bus.mem_to_reg    = mem_to_reg_s;
    assign bus.reg_dst       = reg_dst_s;
    assign bus.reg_write     = reg_write_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.pc_source     = pc_source_s;
    assign bus.state         = state_q;
    assign bus.illegal       = illegal_q;
    assign bus.mem_timeout   = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: table-driven instruction
// vectors plus hand-written reset, watchdog and illegal-opcode sequences.
module tb_multicycle_control_fsm;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic clk;
    logic rst_n;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(
        .MEM_WAIT_MAX (4),
        .WAIT_CNT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        logic       zero;
        logic [3:0] st;
        logic       ill;
        logic       tmo;
    } vec_t;

    vec_t        vecs[$];
    logic [21:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Expected outputs for a state, from the controller's published strobe table.
    function automatic logic [21:0] exp_word(input logic [3:0] st, input logic rdy,
                                             input logic ill, input logic tmo);
        logic ir, pw, pwc, io, mr, mw, m2r, rd, rw, sa;
        logic [1:0] sb, aop, ps;
        {ir, pw, pwc, io, mr, mw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; ir = rdy; pw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; io = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {st, ir, pw, pwc, io, mr, mw, m2r, rd, rw, sa, sb, aop, ps, ill, tmo};
    endfunction

    function automatic logic [21:0] dut_word();
        return {bus.state, bus.ir_load, bus.pc_write, bus.pc_write_cond, bus.iord,
                bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.illegal, bus.mem_timeout};
    endfunction

    function automatic void add_vec(input logic [5:0] op, input logic rdy, input logic zero,
                                    input logic [3:0] st, input logic ill, input logic tmo);
        vec_t v;
        v.op = op; v.rdy = rdy; v.zero = zero; v.st = st; v.ill = ill; v.tmo = tmo;
        vecs.push_back(v);
    endfunction

    task automatic compare(input string name);
        logic [21:0] exp;
        logic [21:0] got;
        got = dut_word();
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty got=%h", name, got);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s got state=%0d word=%h exp state=%0d word=%h",
                         name, got[21:18], got, exp[21:18], exp);
            end
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, check at the negedge,
    // and return at the next posedge+1.
    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input logic zero, input logic [3:0] st,
                        input logic ill, input logic tmo);
        bus.opcode    = op;
        bus.funct     = 6'($urandom_range(0, 63));
        bus.zero      = zero;
        bus.mem_ready = rdy;
        exp_q.push_back(exp_word(st, rdy, ill, tmo));
        @(negedge clk);
        compare(name);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset, checked while still asserted; release at posedge+1.
    task automatic do_reset(input string name);
        bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_word(4'd0, 1'b0, 1'b0, 1'b0));
        compare(name);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.opcode    = RT;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // lw, sw, R-type with fetch stall, beq, j, addi, lw completing on the limit cycle
        add_vec(LW, 1, 0, 0, 0, 0); add_vec(LW, 1, 0, 1, 0, 0); add_vec(LW, 1, 0, 2, 0, 0);
        add_vec(LW, 1, 0, 3, 0, 0); add_vec(LW, 1, 0, 4, 0, 0);
        add_vec(SW, 1, 0, 0, 0, 0); add_vec(SW, 1, 0, 1, 0, 0); add_vec(SW, 1, 0, 2, 0, 0);
        add_vec(SW, 1, 0, 5, 0, 0);
        add_vec(RT, 0, 0, 0, 0, 0); add_vec(RT, 0, 0, 0, 0, 0); add_vec(RT, 0, 0, 0, 0, 0);
        add_vec(RT, 1, 0, 0, 0, 0); add_vec(RT, 1, 0, 1, 0, 0); add_vec(RT, 1, 0, 6, 0, 0);
        add_vec(RT, 1, 0, 7, 0, 0);
        add_vec(BEQ, 1, 1, 0, 0, 0); add_vec(BEQ, 1, 1, 1, 0, 0); add_vec(BEQ, 1, 1, 8, 0, 0);
        add_vec(J, 1, 0, 0, 0, 0); add_vec(J, 1, 0, 1, 0, 0); add_vec(J, 1, 0, 11, 0, 0);
        add_vec(ADDI, 1, 0, 0, 0, 0); add_vec(ADDI, 1, 0, 1, 0, 0);
        add_vec(ADDI, 1, 0, 9, 0, 0); add_vec(ADDI, 1, 0, 10, 0, 0);
        add_vec(LW, 1, 0, 0, 0, 0); add_vec(LW, 1, 0, 1, 0, 0); add_vec(LW, 1, 0, 2, 0, 0);
        for (int k = 0; k < 4; k++) add_vec(LW, 0, 0, 3, 0, 0);
        add_vec(LW, 1, 0, 3, 0, 0); add_vec(LW, 1, 0, 4, 0, 0);

        #2;
        do_reset("reset_initial");

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy, vecs[i].zero,
                 vecs[i].st, vecs[i].ill, vecs[i].tmo);
        end

        // Reset asserted while a load is waiting in MEM_READ
        step("mid_lw_fetch", LW, 1, 0, 0, 0, 0);
        step("mid_lw_decode", LW, 1, 0, 1, 0, 0);
        step("mid_lw_addr", LW, 1, 0, 2, 0, 0);
        step("mid_lw_read", LW, 0, 0, 3, 0, 0);
        do_reset("reset_mid_mem_read");

        // Unsupported opcode
        step("ill_fetch", BAD, 1, 0, 0, 0, 0);
        step("ill_decode", BAD, 1, 0, 1, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        step("ill_halt", BAD, 1, 0, 12, 1, 0);
        step("ill_halt_hold", J, 1, 0, 12, 1, 0);
        do_reset("ill_reset_clears");
`else
        step("ill_pulse", BAD, 1, 0, 0, 1, 0);
        step("ill_next_decode", J, 1, 0, 1, 0, 0);
        step("ill_next_jump", J, 1, 0, 11, 0, 0);
        step("ill_next_fetch", J, 1, 0, 0, 0, 0);
        do_reset("ill_reset");
`endif

        // Fetch that never completes
        for (int k = 0; k < 5; k++) step($sformatf("fetch_stall%0d", k), J, 0, 0, 0, 0, 0);
        step("fetch_timeout", J, 1, 0, 12, 0, 1);
        step("fetch_timeout_hold", J, 1, 0, 12, 0, 1);
        do_reset("fetch_timeout_reset");

        // Store that never completes
        step("sw_to_fetch", SW, 1, 0, 0, 0, 0);
        step("sw_to_decode", SW, 1, 0, 1, 0, 0);
        step("sw_to_addr", SW, 1, 0, 2, 0, 0);
        for (int k = 0; k < 5; k++) step($sformatf("sw_stall%0d", k), SW, 0, 0, 5, 0, 0);
        for (int k = 0; k < 3; k++) step($sformatf("sw_halt%0d", k), SW, 1, 0, 12, 0, 1);
        do_reset("sw_timeout_reset");

        // Normal operation resumes after the timeout is cleared
        step("post_fetch", J, 1, 0, 0, 0, 0);
        step("post_decode", J, 1, 0, 1, 0, 0);
        step("post_jump", J, 1, 0, 11, 0, 0);
        step("post_back", J, 1, 0, 0, 0, 0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle MIPS main controller, directly downstream of the instruction register.
- Consumes the decoded opcode/funct fields and produces every datapath strobe, including ir_load, which in turn drives the instruction register's load input.
- Sequences FETCH → DECODE → execute phases.
- Handshakes with a variable-latency memory via mem_ready.
- Watchdogs stalled memory accesses.

Parameters:
- MEM_WAIT_MAX, 15: max cycles a memory state may wait for mem_ready before the timeout fires (1..255).
- WAIT_CNT_W, 8: width of the wait counter; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction bits [31:26] from the instruction register.
- funct  in  6  instruction bits [5:0]; carried through, not decoded here (ALU control owns it).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- ir_load  out  1  instruction register load strobe.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if zero.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  register write data from MDR.
- reg_dst  out  1  destination rd (1) / rt (0).
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding (debug).
- illegal  out  1  unsupported opcode detected.
- mem_timeout  out  1  memory wait exceeded MEM_WAIT_MAX.

Behaviour:

States and encoding:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11, HALT=12.

Reset:
- rst_n=0 forces state=FETCH and wait_cnt=0, and clears illegal/mem_timeout.
- Takes effect immediately, including mid-instruction; no partial writes complete.

Output model:
- Outputs are Moore decodes of the registered state. Exceptions: ir_load and pc_write in FETCH are additionally gated by mem_ready.
- Every strobe not listed for a state is 0.

Per-state outputs and transitions:
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_load=pc_write=mem_ready.
  - Transition: stays until mem_ready=1, then → DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Transition by opcode: 100011/101011 → MEM_ADDR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDI_EX; 000010 → JUMP; anything else → illegal handling.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read=1, iord=1.
  - Transition: waits for mem_ready, then → MEM_WB.
- MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Transition: → FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, iord=1.
  - Transition: waits for mem_ready, then → FETCH.
- EXECUTE:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Transition: → ALU_WB.
- ALU_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Transition: → FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - Transition: → FETCH.
- ADDI_EX:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Transition: → ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dst=0.
  - Transition: → FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Transition: → FETCH.

Memory wait watchdog:
- wait_cnt increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
- wait_cnt clears on leaving those states or when mem_ready=1.
- When wait_cnt reaches MEM_WAIT_MAX with mem_ready still 0:
  - mem_timeout is set (sticky until reset).
  - state → HALT.
- mem_ready=1 on the same cycle the limit is reached: the access completes normally and no timeout is raised.

HALT:
- All strobes are 0 and state holds until reset.

Instruction latencies (mem_ready already high):
- lw = 5 cycles; sw, R-type, addi = 4; beq, j = 3.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE sets illegal (sticky) and moves to HALT.
- Undefined:
  - illegal pulses high for exactly one cycle, the cycle after DECODE.
  - That cycle is spent in FETCH; the instruction is skipped (no register or memory write).

Test Plan:
- Reset with rst_n=0 mid-MEM_READ → next sample shows state=0; mem_write=reg_write=0, illegal=0, mem_timeout=0.
- lw (opcode 100011), mem_ready tied 1 → state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; ir_load high exactly one cycle.
- R-type (opcode 000000) with mem_ready low 3 cycles in FETCH → ir_load=0 for those 3 cycles; ir_load=pc_write=1 on the 4th; then states 1,6,7,0 with alu_op=10 in state 6.
- beq (000100) with zero=1 → state 8 shows pc_write_cond=1, pc_source=01, alu_op=01; j (000010) → state 11 shows pc_write=1, pc_source=10.
- MEM_WAIT_MAX=4, sw with mem_ready held 0 → after 4 wait cycles mem_timeout=1, state=12; held until rst_n pulse.
- Opcode 111111 → illegal behaviour per ILLEGAL_TRAP_EN (defined: state=12, illegal sticky; undefined: one-cycle illegal pulse, next fetch proceeds normally).
